// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU between two valid/ready requesters.
// Issue is combinational and the response follows one cycle later; an unaccepted response blocks new grants.
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              in_rst_n,
  input  logic              in_req0_valid,
  input  logic [DATA_W-1:0] in_req0_a,
  input  logic [DATA_W-1:0] in_req0_b,
  input  logic [2:0]        in_req0_op,
  output logic              out_req0_ready,
  input  logic              in_req1_valid,
  input  logic [DATA_W-1:0] in_req1_a,
  input  logic [DATA_W-1:0] in_req1_b,
  input  logic [2:0]        in_req1_op,
  output logic              out_req1_ready,
  output logic [DATA_W-1:0] out_alu_a,
  output logic [DATA_W-1:0] out_alu_b,
  output logic [2:0]        out_alu_op,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic              in_alu_zero,
  input  logic              in_alu_neg,
  output logic              out_rsp_valid,
  output logic              out_rsp_id,
  output logic [DATA_W-1:0] out_rsp_result,
  output logic              out_rsp_zero,
  output logic              out_rsp_neg,
  input  logic              in_rsp_ready,
  output logic [CNT_W-1:0]  out_grant_cnt0,
  output logic [CNT_W-1:0]  out_grant_cnt1
);

  localparam logic [2:0] OP_NOP = 3'b011;

  logic             rsp_valid;
  logic             rsp_id;
  logic             last_grant;
  logic [CNT_W-1:0] grant_cnt0;
  logic [CNT_W-1:0] grant_cnt1;
  logic             slot_open;
  logic             grant0;
  logic             grant1;

  // Reset gates the grant so readies and the ALU drive are idle while reset is held.
  assign slot_open = in_rst_n && (!rsp_valid || in_rsp_ready);
  assign grant0    = slot_open && in_req0_valid && (!in_req1_valid || last_grant);
  assign grant1    = slot_open && in_req1_valid && (!in_req0_valid || !last_grant);

  assign out_req0_ready = grant0;
  assign out_req1_ready = grant1;

  always_comb begin
    out_alu_a  = '0;
    out_alu_b  = '0;
    out_alu_op = OP_NOP;
    if (grant0) begin
      out_alu_a  = in_req0_a;
      out_alu_b  = in_req0_b;
      out_alu_op = in_req0_op;
    end else if (grant1) begin
      out_alu_a  = in_req1_a;
      out_alu_b  = in_req1_b;
      out_alu_op = in_req1_op;
    end
  end

  always_ff @(posedge clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      last_grant <= 1'b1;
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (grant0 || grant1) begin
        rsp_valid  <= 1'b1;
        rsp_id     <= grant1;
        last_grant <= grant1;
      end else if (in_rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      if (grant0) grant_cnt0 <= grant_cnt0 + CNT_W'(1);
      if (grant1) grant_cnt1 <= grant_cnt1 + CNT_W'(1);
    end
  end

  assign out_rsp_valid  = rsp_valid;
  assign out_rsp_id     = rsp_id;
  assign out_rsp_result = in_alu_result;
  assign out_rsp_zero   = in_alu_zero;
  assign out_rsp_neg    = in_alu_neg;
  assign out_grant_cnt0 = grant_cnt0;
  assign out_grant_cnt1 = grant_cnt1;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural registered ALU, a directed vector table and hand-written reset/wrap sequences.
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic        v0, v1, rr;
  logic [31:0] a0, b0, a1, b1;
  logic [2:0]  op0, op1;
  logic        r0, r1;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_res;
  logic        alu_zero, alu_neg;
  logic        rsp_valid, rsp_id, rsp_zero, rsp_neg;
  logic [31:0] rsp_result;
  logic [15:0] cnt0, cnt1;

  logic        s_r0, s_r1, s_rv, s_id, s_z, s_n;
  logic [31:0] s_a, s_b, s_res;
  logic [2:0]  s_op;
  logic [1:0]  s_c0, s_c1;

  int total;
  int passed;

  alu_arbiter #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .in_rst_n(rst_n),
    .in_req0_valid(v0), .in_req0_a(a0), .in_req0_b(b0), .in_req0_op(op0), .out_req0_ready(r0),
    .in_req1_valid(v1), .in_req1_a(a1), .in_req1_b(b1), .in_req1_op(op1), .out_req1_ready(r1),
    .out_alu_a(alu_a), .out_alu_b(alu_b), .out_alu_op(alu_op),
    .in_alu_result(alu_res), .in_alu_zero(alu_zero), .in_alu_neg(alu_neg),
    .out_rsp_valid(rsp_valid), .out_rsp_id(rsp_id), .out_rsp_result(rsp_result),
    .out_rsp_zero(rsp_zero), .out_rsp_neg(rsp_neg), .in_rsp_ready(rr),
    .out_grant_cnt0(cnt0), .out_grant_cnt1(cnt1)
  );

  // Narrow-counter instance sees the same stimulus; only its counters are checked.
  alu_arbiter #(.DATA_W(32), .CNT_W(2)) dut_small (
    .clk(clk), .in_rst_n(rst_n),
    .in_req0_valid(v0), .in_req0_a(a0), .in_req0_b(b0), .in_req0_op(op0), .out_req0_ready(s_r0),
    .in_req1_valid(v1), .in_req1_a(a1), .in_req1_b(b1), .in_req1_op(op1), .out_req1_ready(s_r1),
    .out_alu_a(s_a), .out_alu_b(s_b), .out_alu_op(s_op),
    .in_alu_result(alu_res), .in_alu_zero(alu_zero), .in_alu_neg(alu_neg),
    .out_rsp_valid(s_rv), .out_rsp_id(s_id), .out_rsp_result(s_res),
    .out_rsp_zero(s_z), .out_rsp_neg(s_n), .in_rsp_ready(rr),
    .out_grant_cnt0(s_c0), .out_grant_cnt1(s_c1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Registered ALU; NOP and undefined opcodes hold result and flags.
  logic [31:0] alu_nxt;
  logic        alu_upd;
  always_comb begin
    alu_nxt = alu_res;
    alu_upd = 1'b1;
    case (alu_op)
      3'b100:  alu_nxt = alu_b + alu_a;
      3'b010:  alu_nxt = alu_a + 32'd1;
      3'b001:  alu_nxt = 32'd0 - alu_a;
      3'b000:  alu_nxt = alu_b - alu_a;
      3'b111:  alu_nxt = alu_a;
      default: alu_upd = 1'b0;
    endcase
  end

  initial begin
    alu_res  = 32'd0;
    alu_zero = 1'b1;
    alu_neg  = 1'b0;
  end

  always @(posedge clk) begin
    if (alu_upd) begin
      alu_res  <= alu_nxt;
      alu_zero <= (alu_nxt == 32'd0);
      alu_neg  <= alu_nxt[31];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic        v0; logic [31:0] a0; logic [31:0] b0; logic [2:0] op0;
    logic        v1; logic [31:0] a1; logic [31:0] b1; logic [2:0] op1;
    logic        rr;
    logic        e_r0; logic e_r1; logic [2:0] e_op; logic [31:0] e_a;
    logic        e_rv; logic e_id; logic [31:0] e_res; logic e_z; logic e_n;
    logic [15:0] e_c0; logic [15:0] e_c1;
  } vec_t;

  localparam int NV = 15;
  vec_t vec [NV];

  task automatic drive(input logic nv0, input logic [31:0] na0, input logic [31:0] nb0, input logic [2:0] nop0,
                       input logic nv1, input logic [31:0] na1, input logic [31:0] nb1, input logic [2:0] nop1,
                       input logic nrr);
    v0 = nv0; a0 = na0; b0 = nb0; op0 = nop0;
    v1 = nv1; a1 = na1; b1 = nb1; op1 = nop1;
    rr = nrr;
  endtask

  initial begin
    logic [1:0] wrap_exp [5];
    wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3; wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;

    //         v0 a0     b0 op0     v1 a1            b1 op1    rr  r0 r1 op      alu_a          rv id res            z  n  c0 c1
    vec[0]  = '{1, 5,     7, 3'b100, 0, 0,            0, 3'b011, 1, 1, 0, 3'b100, 5,             1, 0, 12,            0, 0, 1, 0};
    vec[1]  = '{0, 0,     0, 3'b011, 1, 32'h80000000, 0, 3'b111, 1, 0, 1, 3'b111, 32'h80000000, 1, 1, 32'h80000000, 0, 1, 1, 1};
    vec[2]  = '{1, 1,     0, 3'b010, 1, 10,           0, 3'b010, 1, 1, 0, 3'b010, 1,             1, 0, 2,             0, 0, 2, 1};
    vec[3]  = '{1, 1,     0, 3'b010, 1, 10,           0, 3'b010, 1, 0, 1, 3'b010, 10,            1, 1, 11,            0, 0, 2, 2};
    vec[4]  = '{1, 1,     0, 3'b010, 1, 10,           0, 3'b010, 1, 1, 0, 3'b010, 1,             1, 0, 2,             0, 0, 3, 2};
    vec[5]  = '{1, 1,     0, 3'b010, 1, 10,           0, 3'b010, 1, 0, 1, 3'b010, 10,            1, 1, 11,            0, 0, 3, 3};
    vec[6]  = '{0, 0,     0, 3'b011, 1, 3,            3, 3'b000, 1, 0, 1, 3'b000, 3,             1, 1, 0,             1, 0, 3, 4};
    vec[7]  = '{1, 5,     7, 3'b100, 0, 0,            0, 3'b011, 0, 0, 0, 3'b011, 0,             1, 1, 0,             1, 0, 3, 4};
    vec[8]  = '{1, 5,     7, 3'b100, 0, 0,            0, 3'b011, 0, 0, 0, 3'b011, 0,             1, 1, 0,             1, 0, 3, 4};
    vec[9]  = '{1, 5,     7, 3'b100, 0, 0,            0, 3'b011, 0, 0, 0, 3'b011, 0,             1, 1, 0,             1, 0, 3, 4};
    vec[10] = '{1, 5,     7, 3'b100, 0, 0,            0, 3'b011, 1, 1, 0, 3'b100, 5,             1, 0, 12,            0, 0, 4, 4};
    vec[11] = '{1, 1,     0, 3'b001, 0, 0,            0, 3'b011, 1, 1, 0, 3'b001, 1,             1, 0, 32'hFFFFFFFF,  0, 1, 5, 4};
    vec[12] = '{1, 9,     9, 3'b011, 0, 0,            0, 3'b011, 1, 1, 0, 3'b011, 9,             1, 0, 32'hFFFFFFFF,  0, 1, 6, 4};
    vec[13] = '{0, 0,     0, 3'b011, 0, 0,            0, 3'b011, 1, 0, 0, 3'b011, 0,             0, 0, 0,             0, 0, 6, 4};
    vec[14] = '{0, 0,     0, 3'b011, 1, 4,            0, 3'b101, 1, 0, 1, 3'b101, 4,             1, 1, 32'hFFFFFFFF,  0, 1, 6, 5};

    total = 0;
    passed = 0;
    rst_n = 1'b0;
    drive(0, 0, 0, 3'b011, 0, 0, 0, 3'b011, 1);

    repeat (3) @(posedge clk);
    #1;
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_id", 32'(rsp_id), 32'd0);
    check("reset ready0", 32'(r0), 32'd0);
    check("reset alu_op", 32'(alu_op), 32'd3);
    check("reset cnt0", 32'(cnt0), 32'd0);
    check("reset cnt1", 32'(cnt1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vec[i].v0, vec[i].a0, vec[i].b0, vec[i].op0, vec[i].v1, vec[i].a1, vec[i].b1, vec[i].op1, vec[i].rr);
      #1;
      check($sformatf("v%0d ready0", i), 32'(r0), 32'(vec[i].e_r0));
      check($sformatf("v%0d ready1", i), 32'(r1), 32'(vec[i].e_r1));
      check($sformatf("v%0d alu_op", i), 32'(alu_op), 32'(vec[i].e_op));
      check($sformatf("v%0d alu_a", i), alu_a, vec[i].e_a);
      @(posedge clk);
      #1;
      check($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), 32'(vec[i].e_rv));
      if (vec[i].e_rv) begin
        check($sformatf("v%0d rsp_id", i), 32'(rsp_id), 32'(vec[i].e_id));
        check($sformatf("v%0d rsp_result", i), rsp_result, vec[i].e_res);
        check($sformatf("v%0d rsp_zero", i), 32'(rsp_zero), 32'(vec[i].e_z));
        check($sformatf("v%0d rsp_neg", i), 32'(rsp_neg), 32'(vec[i].e_n));
      end
      check($sformatf("v%0d cnt0", i), 32'(cnt0), 32'(vec[i].e_c0));
      check($sformatf("v%0d cnt1", i), 32'(cnt1), 32'(vec[i].e_c1));
    end

    // Mid-cycle reset while a response is pending and req0 is waiting.
    @(negedge clk);
    drive(1, 5, 7, 3'b100, 0, 0, 0, 3'b011, 0);
    #1;
    check("pending ready0", 32'(r0), 32'd0);
    check("pending rsp_valid", 32'(rsp_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("async rst ready0", 32'(r0), 32'd0);
    check("async rst alu_op", 32'(alu_op), 32'd3);
    check("async rst alu_a", alu_a, 32'd0);
    check("async rst cnt0", 32'(cnt0), 32'd0);
    check("async rst cnt1", 32'(cnt1), 32'd0);
    check("async rst small cnt0", 32'(s_c0), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 1, 0, 3'b010, 1, 10, 0, 3'b010, 1);
    #1;
    check("post rst tie ready0", 32'(r0), 32'd1);
    check("post rst tie ready1", 32'(r1), 32'd0);
    @(posedge clk);
    #1;
    check("post rst rsp_id", 32'(rsp_id), 32'd0);
    check("post rst rsp_result", rsp_result, 32'd2);
    check("wrap cnt0 step 0", 32'(s_c0), 32'(wrap_exp[0]));

    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      drive(1, 5, 7, 3'b100, 0, 0, 0, 3'b011, 1);
      #1;
      check($sformatf("wrap ready0 step %0d", k), 32'(r0), 32'd1);
      @(posedge clk);
      #1;
      check($sformatf("wrap cnt0 step %0d", k), 32'(s_c0), 32'(wrap_exp[k]));
      check($sformatf("wide cnt0 step %0d", k), 32'(cnt0), 32'(k + 1));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
